// File: rtl/pci_bus_resolver.sv
// Clocked PCI control-bus model: resolves shared active-low FRAME#/IRDY#/TRDY#/DEVSEL#
// from per-agent drive/enable pairs and tracks phase, beats, aborts and sticky errors.
module pci_bus_resolver #(
    parameter int N_AGENTS       = 4,
    parameter int CNT_W          = 8,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_AGENTS-1:0] frame_oe,
    input  logic [N_AGENTS-1:0] frame_drv,
    input  logic [N_AGENTS-1:0] irdy_oe,
    input  logic [N_AGENTS-1:0] irdy_drv,
    input  logic [N_AGENTS-1:0] trdy_oe,
    input  logic [N_AGENTS-1:0] trdy_drv,
    input  logic [N_AGENTS-1:0] devsel_oe,
    input  logic [N_AGENTS-1:0] devsel_drv,
    input  logic                clr_err,
    output logic                frame_bus,
    output logic                irdy_bus,
    output logic                trdy_bus,
    output logic                devsel_bus,
    output logic [1:0]          bus_phase,
    output logic [CNT_W-1:0]    data_count,
    output logic                xfer_done,
    output logic                master_abort,
    output logic [3:0]          contention,
    output logic                proto_err
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_ADDR = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;
    localparam logic [1:0] PH_TURN = 2'd3;

    localparam logic [N_AGENTS-1:0] AGENT_ONE = {{(N_AGENTS-1){1'b0}}, 1'b1};
    localparam logic [N_AGENTS-1:0] AGENT_NONE = {N_AGENTS{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    WAIT_LAST = CNT_W'(DEVSEL_TIMEOUT - 1);

    // Clearing the lowest set bit leaves something only when two or more agents drive.
    function automatic logic multi_drive(input logic [N_AGENTS-1:0] oe);
        return (oe & (oe - AGENT_ONE)) != AGENT_NONE;
    endfunction

    // Pull-up when idle, forced deasserted on contention, otherwise the lone driver's bit.
    function automatic logic resolve_line(input logic [N_AGENTS-1:0] oe,
                                          input logic [N_AGENTS-1:0] drv);
        logic res;
        if (oe == AGENT_NONE) begin
            res = 1'b1;
        end else if (multi_drive(oe)) begin
            res = 1'b1;
        end else begin
            res = |(oe & drv);
        end
        return res;
    endfunction

    logic [1:0]       phase_r, phase_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [CNT_W-1:0] wait_r, wait_nxt_s;
    logic             seen_r, seen_nxt_s;
    logic             done_r, done_nxt_s;
    logic             abort_r, abort_nxt_s;
    logic [3:0]       contention_r, multi_s;
    logic             proto_r, proto_set_s;
    logic             beat_s, timeout_s;

    assign frame_bus  = resolve_line(frame_oe, frame_drv);
    assign irdy_bus   = resolve_line(irdy_oe, irdy_drv);
    assign trdy_bus   = resolve_line(trdy_oe, trdy_drv);
    assign devsel_bus = resolve_line(devsel_oe, devsel_drv);

    assign multi_s = {multi_drive(devsel_oe), multi_drive(trdy_oe),
                      multi_drive(irdy_oe), multi_drive(frame_oe)};

    assign beat_s    = (irdy_bus == 1'b0) && (trdy_bus == 1'b0);
    // Wait counter freezes once DEVSEL# has been seen, so it can only time out before then.
    assign timeout_s = !seen_r && devsel_bus && (wait_r == WAIT_LAST);

    // Next-state and next-output decode for the bus phase tracker.
    always_comb begin
        phase_nxt_s = phase_r;
        count_nxt_s = count_r;
        wait_nxt_s  = wait_r;
        seen_nxt_s  = seen_r;
        done_nxt_s  = 1'b0;
        abort_nxt_s = 1'b0;
        proto_set_s = 1'b0;
        case (phase_r)
            PH_IDLE: begin
                if (!frame_bus) begin
                    phase_nxt_s = PH_ADDR;
                    count_nxt_s = {CNT_W{1'b0}};
                    wait_nxt_s  = {CNT_W{1'b0}};
                    seen_nxt_s  = 1'b0;
                end else begin
                    phase_nxt_s = PH_IDLE;
                end
            end
            PH_ADDR: begin
                phase_nxt_s = PH_DATA;
            end
            PH_DATA: begin
                if (timeout_s) begin
                    abort_nxt_s = 1'b1;
                    phase_nxt_s = PH_TURN;
                end else begin
                    if (beat_s && (count_r != CNT_MAX)) begin
                        count_nxt_s = count_r + CNT_ONE;
                    end else begin
                        count_nxt_s = count_r;
                    end
                    if (!seen_r && devsel_bus) begin
                        wait_nxt_s = wait_r + CNT_ONE;
                    end else begin
                        wait_nxt_s = wait_r;
                    end
                    seen_nxt_s = seen_r | !devsel_bus;
                    if (frame_bus && beat_s) begin
                        done_nxt_s  = 1'b1;
                        phase_nxt_s = PH_TURN;
                    end else if (frame_bus && irdy_bus) begin
                        phase_nxt_s = PH_TURN;
                    end else begin
                        phase_nxt_s = PH_DATA;
                    end
                end
            end
            PH_TURN: begin
                phase_nxt_s = PH_IDLE;
                proto_set_s = !frame_bus;
            end
            default: begin
                phase_nxt_s = PH_IDLE;
            end
        endcase
    end

    // State, counters and sticky flags; set conditions beat a coincident clr_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r      <= PH_IDLE;
            count_r      <= {CNT_W{1'b0}};
            wait_r       <= {CNT_W{1'b0}};
            seen_r       <= 1'b0;
            done_r       <= 1'b0;
            abort_r      <= 1'b0;
            contention_r <= 4'b0000;
            proto_r      <= 1'b0;
        end else begin
            phase_r      <= phase_nxt_s;
            count_r      <= count_nxt_s;
            wait_r       <= wait_nxt_s;
            seen_r       <= seen_nxt_s;
            done_r       <= done_nxt_s;
            abort_r      <= abort_nxt_s;
            contention_r <= (contention_r & ~{4{clr_err}}) | multi_s;
            proto_r      <= (proto_r & ~clr_err) | proto_set_s;
        end
    end

    assign bus_phase    = phase_r;
    assign data_count   = count_r;
    assign xfer_done    = done_r;
    assign master_abort = abort_r;
    assign contention   = contention_r;
    assign proto_err    = proto_r;

endmodule
